srt_qreg_unit: RTL and testbench

Parametrised quotient/partial-remainder register unit for the radix-2 SRT divider datapath. It holds the partial remainder A, the quotient register Q and the negative-digit register Q_star. Per accepted step it shifts {A,Q} and Q_star left by one and inserts one signed quotient digit {-1,0,+1}. After WIDTH steps it converts the redundant pair into the final quotient Q − Q_star. It sits between the divider control FSM and the external add/subtract stage, which writes the updated remainder back through the A write port.

---
 rtl/srt_qreg_unit.sv | 221 ++++++++++++++++++++++
 tb/tb_srt_qreg_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/srt_qreg_unit.sv
// Quotient / partial-remainder register unit for a radix-2 SRT divider.
// Optional build macro SRT_QREG_OTF_CONV_EN selects on-the-fly quotient conversion.
module srt_qreg_unit #(
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_b,
    input  logic                         load,
    input  logic [WIDTH:0]               a_in,
    input  logic [WIDTH-1:0]             q_in,
    input  logic                         a_wr,
    input  logic [WIDTH:0]               a_wdata,
    input  logic                         step_valid,
    input  logic [1:0]                   digit,
    output logic                         step_ready,
    output logic [WIDTH:0]               a_out,
    output logic [WIDTH-1:0]             q_out,
    output logic [WIDTH-1:0]             q_star_out,
    output logic [WIDTH-1:0]             quotient,
    output logic [$clog2(WIDTH+1)-1:0]   step_cnt,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CONV  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH:0]    a_q, a_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic [WIDTH-1:0]  qs_q, qs_d;
    logic [WIDTH-1:0]  quot_q, quot_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              step_ready_q, step_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              d_pos_s, d_neg_s, d_ill_s;

`ifdef SRT_QREG_OTF_CONV_EN
    logic [WIDTH-1:0]  qf_q, qf_d;
    logic [WIDTH-1:0]  qm_q, qm_d;
`else
    logic [CW-1:0]     conv_cnt_q, conv_cnt_d;
    logic              borrow_q, borrow_d;
    logic [WIDTH-1:0]  q_sh_s, qs_sh_s, diff_mask_s;
    logic [1:0]        sub_s;

    // One bit of Q - Q_star: returns {borrow_out, difference}.
    function automatic logic [1:0] sub_bit(input logic x, input logic y, input logic b);
        sub_bit = {(~x & y) | (~(x ^ y) & b), x ^ y ^ b};
    endfunction
`endif

    // Next-state logic: load beats a_wr, which beats a digit step.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        qs_d    = qs_q;
        quot_d  = quot_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        d_pos_s = (digit == 2'b01);
        d_neg_s = (digit == 2'b11);
        d_ill_s = (digit == 2'b10);
`ifdef SRT_QREG_OTF_CONV_EN
        qf_d    = qf_q;
        qm_d    = qm_q;
`else
        conv_cnt_d  = conv_cnt_q;
        borrow_d    = borrow_q;
        q_sh_s      = q_q >> conv_cnt_q;
        qs_sh_s     = qs_q >> conv_cnt_q;
        sub_s       = sub_bit(q_sh_s[0], qs_sh_s[0], borrow_q);
        diff_mask_s = {{(WIDTH-1){1'b0}}, sub_s[0]} << conv_cnt_q;
`endif
        if (load) begin
            state_d = ST_SHIFT;
            a_d     = a_in;
            q_d     = q_in;
            qs_d    = '0;
            quot_d  = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
`ifdef SRT_QREG_OTF_CONV_EN
            qf_d    = '0;
            qm_d    = '1;
`else
            conv_cnt_d = '0;
            borrow_d   = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_SHIFT: begin
                    if (a_wr) begin
                        a_d = a_wdata;
                    end else if (step_valid) begin
                        {a_d, q_d} = {a_q[WIDTH-1:0], q_q, d_pos_s};
                        qs_d  = {qs_q[WIDTH-2:0], d_neg_s};
                        err_d = err_q | d_ill_s;
                        cnt_d = cnt_q + CW'(1);
`ifdef SRT_QREG_OTF_CONV_EN
                        // QF tracks Q, QM tracks Q-1; illegal digits behave as 0.
                        case (digit)
                            2'b01: begin
                                qf_d = {qf_q[WIDTH-2:0], 1'b1};
                                qm_d = {qf_q[WIDTH-2:0], 1'b0};
                            end
                            2'b11: begin
                                qf_d = {qm_q[WIDTH-2:0], 1'b1};
                                qm_d = {qm_q[WIDTH-2:0], 1'b0};
                            end
                            default: begin
                                qf_d = {qf_q[WIDTH-2:0], 1'b0};
                                qm_d = {qm_q[WIDTH-2:0], 1'b1};
                            end
                        endcase
                        if (cnt_q == CW'(WIDTH - 1)) begin
                            state_d = ST_DONE;
                            quot_d  = qf_d;
                        end else begin
                            state_d = ST_SHIFT;
                        end
`else
                        if (cnt_q == CW'(WIDTH - 1)) begin
                            state_d    = ST_CONV;
                            conv_cnt_d = '0;
                            borrow_d   = 1'b0;
                        end else begin
                            state_d = ST_SHIFT;
                        end
`endif
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
                ST_CONV: begin
`ifdef SRT_QREG_OTF_CONV_EN
                    state_d = ST_DONE;
`else
                    // quotient was cleared on load, so OR-ing in one bit per cycle is safe.
                    quot_d     = quot_q | diff_mask_s;
                    borrow_d   = sub_s[1];
                    conv_cnt_d = conv_cnt_q + CW'(1);
                    if (conv_cnt_q == CW'(WIDTH - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_CONV;
                    end
`endif
                end
                ST_IDLE: state_d = ST_IDLE;
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
        step_ready_d = (state_d == ST_SHIFT);
        busy_d       = (state_d == ST_SHIFT) || (state_d == ST_CONV);
        done_d       = (state_d == ST_DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q      <= ST_IDLE;
            a_q          <= '0;
            q_q          <= '0;
            qs_q         <= '0;
            quot_q       <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            step_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef SRT_QREG_OTF_CONV_EN
            qf_q         <= '0;
            qm_q         <= '0;
`else
            conv_cnt_q   <= '0;
            borrow_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            q_q          <= q_d;
            qs_q         <= qs_d;
            quot_q       <= quot_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            step_ready_q <= step_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef SRT_QREG_OTF_CONV_EN
            qf_q         <= qf_d;
            qm_q         <= qm_d;
`else
            conv_cnt_q   <= conv_cnt_d;
            borrow_q     <= borrow_d;
`endif
        end
    end

    assign step_ready = step_ready_q;
    assign a_out      = a_q;
    assign q_out      = q_q;
    assign q_star_out = qs_q;
    assign quotient   = quot_q;
    assign step_cnt   = cnt_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_srt_qreg_unit.sv
// Scoreboard bench for srt_qreg_unit: directed digit sequences, expectations queued
// at issue time and compared by a monitor when done rises.
module tb_srt_qreg_unit;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);
`ifdef SRT_QREG_OTF_CONV_EN
    localparam int LAT = 1;
`else
    localparam int LAT = W + 1;
`endif
    localparam logic [1:0] P = 2'b01;
    localparam logic [1:0] Z = 2'b00;
    localparam logic [1:0] N = 2'b11;
    localparam logic [1:0] I = 2'b10;

    logic           clk, rst_b, load, a_wr, step_valid;
    logic [W:0]     a_in, a_wdata;
    logic [W-1:0]   q_in;
    logic [1:0]     digit;
    logic           step_ready, busy, done, err;
    logic [W:0]     a_out;
    logic [W-1:0]   q_out, q_star_out, quotient;
    logic [CW-1:0]  step_cnt;

    typedef struct {
        logic [W-1:0] quot;
        logic [W-1:0] q;
        logic [W-1:0] qs;
        logic [W:0]   a;
        logic         err;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    srt_qreg_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_b(rst_b), .load(load), .a_in(a_in), .q_in(q_in),
        .a_wr(a_wr), .a_wdata(a_wdata), .step_valid(step_valid), .digit(digit),
        .step_ready(step_ready), .a_out(a_out), .q_out(q_out), .q_star_out(q_star_out),
        .quotient(quotient), .step_cnt(step_cnt), .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [W:0] a, input logic [W-1:0] q);
        load = 1'b1; a_in = a; q_in = q;
        tick();
        load = 1'b0;
    endtask

    task automatic do_step(input logic [1:0] d);
        step_valid = 1'b1; digit = d;
        tick();
        step_valid = 1'b0; digit = 2'b00;
    endtask

    // Digits are listed first-step-first in the packed literal (index W-1 first).
    task automatic run_steps(input logic [W-1:0][1:0] ds, input int first, input int n);
        for (int i = first; i > first - n; i--) do_step(ds[i]);
    endtask

    task automatic wait_done(input string name);
        int lat = 1;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        check(name, lat, LAT);
    endtask

    task automatic full_seq(input string name, input logic [W:0] a, input logic [W-1:0] q,
                            input logic [W-1:0][1:0] ds, input exp_t e);
        do_load(a, q);
        sb.push_back(e);
        run_steps(ds, W - 1, W);
        check({name, "_ready_low"}, step_ready, 1'b0);
        wait_done({name, "_latency"});
    endtask

    // Monitor: compare the oldest expectation whenever done rises.
    initial begin
        logic done_prev;
        exp_t e;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (done && !done_prev) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_done", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    check("mon_quotient", quotient, e.quot);
                    check("mon_q_out", q_out, e.q);
                    check("mon_q_star", q_star_out, e.qs);
                    check("mon_a_out", a_out, e.a);
                    check("mon_err", err, e.err);
                    check("mon_step_cnt", step_cnt, W);
                end
            end
            done_prev = done;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e1, e2, e3, e4;
        e1 = '{quot: 8'h71, q: 8'h92, qs: 8'h21, a: 9'h0A5, err: 1'b0};
        e2 = '{quot: 8'h91, q: 8'h92, qs: 8'h01, a: 9'h0A5, err: 1'b1};
        e3 = '{quot: 8'h01, q: 8'h00, qs: 8'hFF, a: 9'h000, err: 1'b0};
        e4 = '{quot: 8'hFF, q: 8'hFF, qs: 8'h00, a: 9'h13C, err: 1'b0};

        rst_b = 1'b0; load = 1'b0; a_wr = 1'b0; step_valid = 1'b0;
        a_in = '0; q_in = '0; a_wdata = '0; digit = 2'b00;
        for (int r = 0; r < 4; r++) begin
            load = 1'($urandom); a_wr = 1'($urandom); step_valid = 1'($urandom);
            a_in = 9'($urandom); q_in = 8'($urandom); a_wdata = 9'($urandom); digit = 2'($urandom);
            tick();
            check("reset_outputs", {step_ready, a_out, q_out, q_star_out, quotient, step_cnt, busy, done, err}, 64'h0);
        end
        load = 1'b0; a_wr = 1'b0; step_valid = 1'b0;
        rst_b = 1'b1;
        tick();
        check("idle_after_reset", {step_ready, busy, done}, 3'b000);

        // Basic sequence: +1,0,-1,+1,0,0,+1,-1.
        do_load(9'h000, 8'hA5);
        check("load_ready", {step_ready, busy, done}, 3'b110);
        sb.push_back(e1);
        run_steps({P, Z, N, P, Z, Z, P, N}, W - 1, W);
        check("last_step_ready_low", step_ready, 1'b0);
        check("busy_after_last", {busy, done}, (LAT == 1) ? 2'b01 : 2'b10);
        wait_done("vec1_latency");
        do_step(P);
        check("step_ignored_in_done", {q_out, done}, {8'h92, 1'b1});

        full_seq("illegal", 9'h000, 8'hA5, {P, Z, I, P, Z, Z, P, N}, e2);
        check("err_sticky", err, 1'b1);
        full_seq("all_neg", 9'h000, 8'h00, {N, N, N, N, N, N, N, N}, e3);
        check("err_cleared", err, 1'b0);
        full_seq("all_pos", 9'h1C3, 8'h3C, {P, P, P, P, P, P, P, P}, e4);

        // Adder write-back collides with a digit; the digit must be dropped.
        do_load(9'h000, 8'hA5);
        do_step(P);
        check("awr_pre", {a_out, q_out, step_cnt}, {9'h001, 8'h4B, 4'd1});
        a_wr = 1'b1; a_wdata = 9'h1FF; step_valid = 1'b1; digit = P;
        tick();
        a_wr = 1'b0; step_valid = 1'b0;
        check("awr_write", {a_out, q_out, step_cnt}, {9'h1FF, 8'h4B, 4'd1});
        do_step(Z);
        check("awr_next_step", {a_out, q_out, step_cnt}, {9'h1FE, 8'h96, 4'd2});
        sb.push_back('{quot: 8'h71, q: 8'h92, qs: 8'h21, a: 9'h1A5, err: 1'b0});
        run_steps({N, P, Z, Z, P, N, Z, Z}, W - 1, 6);
        wait_done("awr_latency");

        // Abort at step 5, then a clean vec1 run.
        do_load(9'h055, 8'h33);
        run_steps({I, P, N, Z, P, Z, Z, Z}, W - 1, 5);
        check("abort5_pre", {step_cnt, err}, {4'd5, 1'b1});
        do_load(9'h000, 8'hA5);
        check("abort5_clean", {step_cnt, q_star_out, err, done, step_ready, q_out, a_out},
              {4'd0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 9'h000});
        sb.push_back(e1);
        run_steps({P, Z, N, P, Z, Z, P, N}, W - 1, W);
        wait_done("abort5_latency");

`ifndef SRT_QREG_OTF_CONV_EN
        // Abort in the middle of serial conversion.
        do_load(9'h000, 8'hA5);
        run_steps({P, Z, I, P, Z, Z, P, N}, W - 1, W);
        tick(); tick();
        check("conv_mid", {busy, done, step_ready}, 3'b100);
        do_load(9'h000, 8'h00);
        check("abort_conv_clean", {step_cnt, q_star_out, err, done, step_ready},
              {4'd0, 8'h00, 1'b0, 1'b0, 1'b1});
        sb.push_back(e3);
        run_steps({N, N, N, N, N, N, N, N}, W - 1, W);
        wait_done("abort_conv_latency");
`endif

        // Asynchronous reset mid-operation takes effect without a clock edge.
        do_load(9'h0F0, 8'h5A);
        run_steps({P, N, P, Z, Z, Z, Z, Z}, W - 1, 3);
        #2;
        rst_b = 1'b0;
        #1;
        check("async_reset", {step_ready, a_out, q_out, q_star_out, quotient, step_cnt, busy, done, err}, 64'h0);
        tick();
        rst_b = 1'b1;
        tick(); tick(); tick();
        check("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
